// File: rtl/fifo_arb_pkg.sv
// Shared types and width/offset helpers for the producer-to-FIFO write arbiter.
// Stored word layout, LSB first: data, then source index, then the last flag.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int src_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int word_width(input int dwidth, input int srcw);
    return dwidth + srcw + 1;
  endfunction

  function automatic int src_lsb(input int dwidth);
    return dwidth;
  endfunction

  function automatic int last_bit(input int dwidth, input int srcw);
    return dwidth + srcw;
  endfunction

  // Round-robin successor; also correct when n is not a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: first set request at or above ptr,
// wrapping modulo NREQ. Produces a one-hot grant (or zero) and its index.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int SRC_W = src_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [SRC_W-1:0] grant_idx
);

  always_comb begin
    int               idx;
    logic [SRC_W-1:0] sel;
    logic             found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = SRC_W'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible combinationally on
// rd_data. Occupancy is tracked by the user, so no flags are produced here.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one tagged FIFO among NREQ producers.
// Optional high-water-mark tracking is enabled with `define FIFO_ARB_HWM_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int DEPTH  = 16,
  parameter  int DWIDTH = 8,
  localparam int SRC_W  = src_width(NREQ),
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        s_valid_i,
  input  logic [NREQ-1:0]        s_last_i,
  input  logic [NREQ*DWIDTH-1:0] s_data_i,
  output logic [NREQ-1:0]        s_ready_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DWIDTH-1:0]      m_data_o,
  output logic [SRC_W-1:0]       m_src_o,
  output logic                   m_last_o,
  output logic [CNT_W-1:0]       level_o
`ifdef FIFO_ARB_HWM_EN
  ,
  output logic [CNT_W-1:0]       hwm_o,
  input  logic                   hwm_clr_i
`endif
);

  localparam int W = word_width(DWIDTH, SRC_W);

  arb_state_e       state_reg, state_next;
  logic [SRC_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [SRC_W-1:0] owner_reg, owner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [NREQ-1:0]   arb_grant, grant;
  logic [SRC_W-1:0]  arb_idx, sel_idx, next_ptr;
  logic [DWIDTH-1:0] data_arr [NREQ];
  logic [DWIDTH-1:0] sel_data;
  logic              sel_last, full, push, pop;
  logic [W-1:0]      wr_word, rd_word;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_data
      assign data_arr[gi] = s_data_i[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req      (s_valid_i),
    .ptr      (rr_ptr_reg),
    .grant    (arb_grant),
    .grant_idx(arb_idx)
  );

  // While locked the owner keeps the grant even with valid low.
  always_comb begin
    grant   = arb_grant;
    sel_idx = arb_idx;
    if (state_reg == LOCK) begin
      grant            = '0;
      grant[owner_reg] = 1'b1;
      sel_idx          = owner_reg;
    end
  end

  assign sel_data  = data_arr[sel_idx];
  assign sel_last  = s_last_i[sel_idx];
  assign full      = (cnt_reg == CNT_W'(DEPTH));
  assign s_ready_o = grant & {NREQ{~full & rst_n}};
  assign push      = |(s_valid_i & s_ready_o);
  assign pop       = m_valid_o & m_ready_i;
  assign cnt_next  = cnt_reg + CNT_W'(push) - CNT_W'(pop);
  assign next_ptr  = SRC_W'(wrap_inc(int'(sel_idx), NREQ));

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    if (push) begin
      case (state_reg)
        ARB: begin
          if (sel_last) begin
            rr_ptr_next = next_ptr;
          end else begin
            state_next = LOCK;
            owner_next = sel_idx;
          end
        end
        LOCK: begin
          if (sel_last) begin
            state_next  = ARB;
            rr_ptr_next = next_ptr;
          end
        end
        default: state_next = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ARB;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign wr_word = {sel_last, sel_idx, sel_data};

  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_data(wr_word),
    .rd_en  (pop),
    .rd_data(rd_word)
  );

  assign m_valid_o = (cnt_reg != '0);
  assign m_data_o  = rd_word[DWIDTH-1:0];
  assign m_src_o   = rd_word[src_lsb(DWIDTH) +: SRC_W];
  assign m_last_o  = rd_word[last_bit(DWIDTH, SRC_W)];
  assign level_o   = cnt_reg;

`ifdef FIFO_ARB_HWM_EN
  logic [CNT_W-1:0] hwm_reg, hwm_next;

  always_comb begin
    hwm_next = hwm_reg;
    if (hwm_clr_i)               hwm_next = cnt_next;
    else if (cnt_next > hwm_reg) hwm_next = cnt_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_reg <= '0;
    else        hwm_reg <= hwm_next;
  end

  assign hwm_o = hwm_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a queue-based packet model.
// Define FIFO_ARB_HWM_EN to also exercise the high-water-mark port.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4, DEPTH = 16, DWIDTH = 8, SRC_W = 2, CNT_W = 5;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic              last;
    logic [DWIDTH-1:0] data;
  } word_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        s_valid_i = '0;
  logic [NREQ-1:0]        s_last_i = '0;
  logic [NREQ*DWIDTH-1:0] s_data_i = '0;
  logic [NREQ-1:0]        s_ready_o;
  logic                   m_valid_o;
  logic                   m_ready_i = 1'b0;
  logic [DWIDTH-1:0]      m_data_o;
  logic [SRC_W-1:0]       m_src_o;
  logic                   m_last_o;
  logic [CNT_W-1:0]       level_o;
`ifdef FIFO_ARB_HWM_EN
  logic [CNT_W-1:0]       hwm_o;
  logic                   hwm_clr_i = 1'b0;
  int                     hwm_m;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid_i(s_valid_i),
    .s_last_i (s_last_i),
    .s_data_i (s_data_i),
    .s_ready_o(s_ready_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_data_o (m_data_o),
    .m_src_o  (m_src_o),
    .m_last_o (m_last_o),
    .level_o  (level_o)
`ifdef FIFO_ARB_HWM_EN
    ,
    .hwm_o    (hwm_o),
    .hwm_clr_i(hwm_clr_i)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Producer stimulus state
  bit          cv [NREQ];
  bit          cl [NREQ];
  logic [7:0]  cd [NREQ];
  int          left [NREQ];
  bit          gen_en [NREQ];
  int          gen_len [NREQ];
  int          gen_prob = 100;
  int          rdy_prob = 100;

  // Reference model: stored words, lock owner, round-robin pointer
  word_t q[$];
  bit    locked;
  int    owner, rr;
  int    pop_src[$];
  int    pop_last[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      s_valid_i[i] = cv[i];
      s_last_i[i]  = cl[i];
      s_data_i[i*DWIDTH +: DWIDTH] = cd[i];
    end
  endtask

  task automatic step();
    int g;
    bit has_g, push, pop;
    logic [NREQ-1:0] rdy;
    for (int i = 0; i < NREQ; i++) begin
      if (!cv[i] && gen_en[i] && $urandom_range(99) < gen_prob) begin
        if (left[i] == 0) left[i] = (gen_len[i] != 0) ? gen_len[i] : int'($urandom_range(1, 4));
        cv[i] = 1'b1;
        cd[i] = 8'($urandom);
        cl[i] = (left[i] == 1);
      end
    end
    m_ready_i = ($urandom_range(99) < rdy_prob);
    drive();
    #1;
    has_g = 1'b0;
    g = 0;
    if (locked) begin
      g = owner;
      has_g = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!has_g && cv[(rr + k) % NREQ]) begin
          g = (rr + k) % NREQ;
          has_g = 1'b1;
        end
      end
    end
    rdy = '0;
    if (has_g && q.size() < DEPTH) rdy[g] = 1'b1;
    check_eq("s_ready", 64'(s_ready_o), 64'(rdy));
    check_eq("m_valid", 64'(m_valid_o), 64'(q.size() != 0));
    check_eq("level", 64'(level_o), 64'(q.size()));
    if (q.size() != 0) begin
      check_eq("m_data", 64'(m_data_o), 64'(q[0].data));
      check_eq("m_src", 64'(m_src_o), 64'(q[0].src));
      check_eq("m_last", 64'(m_last_o), 64'(q[0].last));
    end
`ifdef FIFO_ARB_HWM_EN
    check_eq("hwm", 64'(hwm_o), 64'(hwm_m));
`endif
    push = has_g && rdy[g] && cv[g];
    pop  = (q.size() != 0) && m_ready_i;
    @(posedge clk);
    if (pop) begin
      $display("pop  src=%0d last=%0d data=%02h level=%0d", q[0].src, q[0].last, q[0].data, q.size() - 1 + int'(push));
      pop_src.push_back(int'(q[0].src));
      pop_last.push_back(int'(q[0].last));
      void'(q.pop_front());
    end
    if (push) begin
      q.push_back('{src: SRC_W'(g), last: cl[g], data: cd[g]});
      if (cl[g]) begin
        locked = 1'b0;
        rr = (g + 1) % NREQ;
      end else if (!locked) begin
        locked = 1'b1;
        owner = g;
      end
      left[g]--;
      cv[g] = 1'b0;
    end
`ifdef FIFO_ARB_HWM_EN
    if (hwm_clr_i) hwm_m = q.size();
    else if (q.size() > hwm_m) hwm_m = q.size();
`endif
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_level", 64'(level_o), 64'd0);
    check_eq("rst_m_valid", 64'(m_valid_o), 64'd0);
    check_eq("rst_s_ready", 64'(s_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      cv[i] = 1'b0; cl[i] = 1'b0; cd[i] = '0; left[i] = 0;
      gen_en[i] = 1'b0; gen_len[i] = 1;
    end
    drive();
    m_ready_i = 1'b0;
    q.delete();
    pop_src.delete();
    pop_last.delete();
    locked = 1'b0; owner = 0; rr = 0;
    gen_prob = 100; rdy_prob = 100;
`ifdef FIFO_ARB_HWM_EN
    hwm_m = 0;
    hwm_clr_i = 1'b0;
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_src2 [6];
    int exp_src3 [5];
    int exp_last3 [5];
    exp_src2  = '{0, 1, 2, 3, 0, 1};
    exp_src3  = '{1, 1, 1, 2, 0};
    exp_last3 = '{0, 0, 1, 1, 1};
    @(negedge clk);
    apply_reset();

    // Single-beat packets from everyone: strict rotation
    for (int i = 0; i < NREQ; i++) gen_en[i] = 1'b1;
    repeat (7) step();
    for (int k = 0; k < 6; k++) check_eq("rr_order", 64'(pop_src[k]), 64'(exp_src2[k]));

    // 3-beat packet from producer 1 holds the grant through a valid gap
    apply_reset();
    gen_en[1] = 1'b1; gen_len[1] = 3;
    step();
    gen_en[1] = 1'b0; gen_en[0] = 1'b1; gen_en[2] = 1'b1;
    repeat (2) begin
      step();
      check_eq("lock_gap_ready", 64'(s_ready_o), 64'b0010);
    end
    gen_en[1] = 1'b1;
    repeat (5) step();
    for (int k = 0; k < 5; k++) begin
      check_eq("lock_src", 64'(pop_src[k]), 64'(exp_src3[k]));
      check_eq("lock_last", 64'(pop_last[k]), 64'(exp_last3[k]));
    end

    // Fill to full with the consumer stalled, then one pop
    apply_reset();
    rdy_prob = 0; gen_en[0] = 1'b1;
    repeat (17) step();
    check_eq("full_level", 64'(level_o), 64'd16);
    check_eq("full_ready0", 64'(s_ready_o[0]), 64'd0);
    rdy_prob = 100;
    step();
    check_eq("after_pop_level", 64'(level_o), 64'd15);
    rdy_prob = 0;
    step();
    check_eq("refill_level", 64'(level_o), 64'd16);

    // Steady push and pop at level 1
    apply_reset();
    gen_en[0] = 1'b1; rdy_prob = 0;
    step();
    rdy_prob = 100;
    repeat (10) begin
      step();
      check_eq("steady_level", 64'(level_o), 64'd1);
    end

    // Reset in the middle of a 4-beat packet, then rearbitrate from 0
    apply_reset();
    gen_en[2] = 1'b1; gen_len[2] = 4; rdy_prob = 0;
    repeat (2) step();
    gen_en[2] = 1'b0;
    step();
    apply_reset();
    for (int i = 1; i < NREQ; i++) gen_en[i] = 1'b1;
    repeat (3) step();
    check_eq("post_rst_first_src", 64'(pop_src[0]), 64'd1);

`ifdef FIFO_ARB_HWM_EN
    apply_reset();
    gen_en[0] = 1'b1; rdy_prob = 0;
    repeat (9) step();
    gen_en[0] = 1'b0; rdy_prob = 100;
    repeat (7) step();
    check_eq("hwm_level", 64'(level_o), 64'd2);
    check_eq("hwm_peak", 64'(hwm_o), 64'd9);
    rdy_prob = 0; hwm_clr_i = 1'b1;
    step();
    hwm_clr_i = 1'b0;
    check_eq("hwm_clr", 64'(hwm_o), 64'd2);
`endif

    // Random traffic with variable packet lengths and consumer back-pressure
    apply_reset();
    for (int i = 0; i < NREQ; i++) gen_len[i] = 0;
    for (int i = 0; i < NREQ; i++) gen_en[i] = 1'b1;
    gen_prob = 60;
    rdy_prob = 50; repeat (150) step();
    rdy_prob = 20; repeat (100) step();
    rdy_prob = 90; repeat (150) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
